// File: rtl/apb_chk_pkg.sv
// APB4 protocol checker: shared types and helpers.
// Phase states, error codes and the select-index width function.
package apb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ABANDON = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    E_NONE        = 4'd0,
    E_MULTI_SEL   = 4'd1,
    E_EN_NO_SEL   = 4'd2,
    E_EN_IN_SETUP = 4'd3,
    E_NO_ACCESS   = 4'd4,
    E_CTRL_CHANGE = 4'd5,
    E_TIMEOUT     = 4'd6,
    E_RD_STRB     = 4'd7
  } err_code_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// APB select decoder: any / multiple / lowest asserted index.
// Purely combinational.
module apb_sel_decode
  import apb_chk_pkg::*;
#(
  parameter int NUM_SEL = 4,
  parameter int SW      = sel_width(NUM_SEL)
) (
  input  logic [NUM_SEL-1:0] psel,
  output logic               any,
  output logic               multi,
  output logic [SW-1:0]      idx
);

  assign any   = |psel;
  assign multi = |(psel & (psel - NUM_SEL'(1)));

  always_comb begin
    idx = '0;
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      if (psel[i]) idx = SW'(i);
    end
  end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB4 protocol checker and transfer monitor.
// Tracks each transfer, pulses coded errors, keeps statistics.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_WIDTH-1:0]        paddr,
  input  logic [2:0]                   pprot,
  input  logic [NUM_SEL-1:0]           psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_WIDTH-1:0]        pwdata,
  input  logic [DATA_WIDTH/8-1:0]      pstrb,
  input  logic                         pready,
  input  logic [DATA_WIDTH-1:0]        prdata,
  input  logic                         pslverr,
  input  logic                         clear,
  output logic                         err_valid,
  output logic [3:0]                   err_code,
  output logic [sel_width(NUM_SEL)-1:0] err_sel,
  output logic [6:0]                   err_status,
  output logic [CNT_WIDTH-1:0]         xfer_cnt,
  output logic [CNT_WIDTH-1:0]         slverr_cnt,
  output logic [CNT_WIDTH-1:0]         wait_max
);

  localparam int SW = sel_width(NUM_SEL);
  localparam int SB = DATA_WIDTH / 8;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state;
  state_t                st_nxt;
  logic [WW-1:0]         wait_cnt;
  logic [WW-1:0]         wait_nxt;
  logic                  sel_any;
  logic                  sel_multi;
  logic [SW-1:0]         sel_idx;
  logic [SW-1:0]         cap_idx;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [2:0]            cap_prot;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [SB-1:0]         cap_strb;
  logic [NUM_SEL-1:0]    sel_mask;
  logic [6:0]            flags;
  err_code_t             code;
  logic                  capture;
  logic                  complete;
  logic                  ctrl_diff;
  logic [CNT_WIDTH-1:0]  wait_c;
  logic                  unused_prdata;

  assign unused_prdata = ^prdata;

  apb_sel_decode #(
    .NUM_SEL(NUM_SEL),
    .SW     (SW)
  ) u_dec (
    .psel (psel),
    .any  (sel_any),
    .multi(sel_multi),
    .idx  (sel_idx)
  );

  assign sel_mask  = NUM_SEL'(1) << cap_idx;
  assign ctrl_diff = (paddr  != cap_addr)  ||
                     (pprot  != cap_prot)  ||
                     (pwrite != cap_write) ||
                     (pwdata != cap_wdata) ||
                     (pstrb  != cap_strb);

  // flags[k] corresponds to error code k+1
  always_comb begin
    flags    = '0;
    st_nxt   = state;
    wait_nxt = wait_cnt;
    capture  = 1'b0;
    complete = 1'b0;
    if (sel_multi) flags[0] = 1'b1;
    unique case (state)
      IDLE: begin
        if (sel_any && !pwrite && |pstrb) flags[6] = 1'b1;
        if (penable && sel_any) begin
          flags[2] = 1'b1;
        end else if (penable) begin
          flags[1] = 1'b1;
        end else if (sel_any && !sel_multi) begin
          capture  = 1'b1;
          wait_nxt = '0;
          st_nxt   = ACCESS;
        end
      end
      ACCESS: begin
        if (!penable || psel != sel_mask) begin
          flags[3] = 1'b1;
          st_nxt   = ABANDON;
        end else if (ctrl_diff) begin
          flags[4] = 1'b1;
          st_nxt   = ABANDON;
        end else if (pready) begin
          complete = 1'b1;
          st_nxt   = IDLE;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
          if (wait_cnt == TO_LAST) begin
            flags[5] = 1'b1;
            st_nxt   = ABANDON;
          end
        end
      end
      ABANDON: begin
        if (!sel_any) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    code = E_NONE;
    for (int k = 6; k >= 0; k--) begin
      if (flags[k]) code = err_code_t'(4'(k + 1));
    end
  end

  always_comb begin
    wait_c = CNT_MAX;
    if (32'(wait_cnt) <= 32'(CNT_MAX)) wait_c = CNT_WIDTH'(wait_cnt);
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_idx    <= '0;
      cap_addr   <= '0;
      cap_prot   <= '0;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      cap_strb   <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_sel    <= '0;
      err_status <= '0;
      xfer_cnt   <= '0;
      slverr_cnt <= '0;
      wait_max   <= '0;
    end else begin
      state    <= st_nxt;
      wait_cnt <= wait_nxt;
      if (capture) begin
        cap_idx   <= sel_idx;
        cap_addr  <= paddr;
        cap_prot  <= pprot;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
        cap_strb  <= pstrb;
      end
      err_valid  <= |flags;
      err_code   <= code;
      err_sel    <= (|flags) ? sel_idx : '0;
      err_status <= (clear ? 7'd0 : err_status) | flags;
      // a same-edge event overrides clear
      if (clear) begin
        xfer_cnt   <= '0;
        slverr_cnt <= '0;
        wait_max   <= '0;
      end
      if (complete) begin
        xfer_cnt <= clear ? CNT_ONE : sat_inc(xfer_cnt);
        if (pslverr) begin
          slverr_cnt <= clear ? CNT_ONE : sat_inc(slverr_cnt);
        end
        if (clear || wait_c > wait_max) wait_max <= wait_c;
      end
    end
  end

endmodule

// File: doc/apb_protocol_checker.md
# apb_protocol_checker

Synthesizable, parametrised APB4 protocol checker and transfer monitor for a multi-slave APB segment. It sits passively on the bus, in RTL or bench, next to the master and slave agents. It follows every transfer through a small phase FSM and flags protocol violations with a coded, registered error pulse plus sticky status. It also keeps transfer, slave-error and worst-case wait-state statistics. It never drives the bus.

## Interface
Parameters:
- ADDR_WIDTH, 32, paddr width
- DATA_WIDTH, 32, pwdata/prdata width; multiple of 8
- NUM_SEL, 4, number of psel lines (slaves); 1..16
- TIMEOUT, 16, maximum wait states before a timeout error; ≥1
- CNT_WIDTH, 16, statistics counter width

Ports:
- clk  in  1  bus clock; all sampling on rising edge
- reset_n  in  1  asynchronous, active-low reset
- paddr  in  ADDR_WIDTH  address
- pprot  in  3  protection type
- psel  in  NUM_SEL  slave selects
- penable  in  1  access phase
- pwrite  in  1  1 = write
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  write strobes
- pready  in  1  slave ready
- prdata  in  DATA_WIDTH  read data (observed only)
- pslverr  in  1  slave error
- clear  in  1  synchronous clear of statistics and sticky status
- err_valid  out  1  one-cycle error pulse
- err_code  out  4  error code, valid with err_valid
- err_sel  out  $clog2(NUM_SEL) max 1  index of the offending slave select
- err_status  out  7  sticky; bit (code−1) set when that code occurs
- xfer_cnt  out  CNT_WIDTH  completed transfers, saturating
- slverr_cnt  out  CNT_WIDTH  completions with pslverr=1, saturating
- wait_max  out  CNT_WIDTH  largest wait-state count of any completed transfer

## Operation
- FSM states:
  - IDLE: no transfer open.
  - ACCESS: setup seen; access phase expected.
  - ABANDON: transfer dead; wait for the bus to idle.
- IDLE:
  - One psel bit set and penable=0: capture the select index, paddr, pprot, pwrite, pwdata and pstrb; clear wait_cnt; go to ACCESS.
  - Any psel set and penable=1: error 3.
  - penable=1 with no psel: error 2.
- ACCESS:
  - penable must be 1 and the same single select must still be asserted; otherwise error 4 and go to ABANDON.
  - Any captured control/data field differs from the current value: error 5 and go to ABANDON.
  - pready=1: transfer completes. Increment xfer_cnt. Increment slverr_cnt if pslverr=1. Set wait_max to max(wait_max, wait_cnt). Go to IDLE.
  - pready=0: wait_cnt+1. When wait_cnt reaches TIMEOUT, raise error 6 and go to ABANDON.
- ABANDON: return to IDLE on the first sample with no psel set. No new errors are raised except code 1.
- Checked in every state:
  - Error 1: more than one psel bit set.
  - Error 7: setup sampled with pwrite=0 and pstrb≠0.
- Error codes: 1 MULTI_SEL, 2 EN_NO_SEL, 3 EN_IN_SETUP, 4 NO_ACCESS, 5 CTRL_CHANGE, 6 TIMEOUT, 7 RD_STRB.
- Multiple errors in one sample:
  - err_code reports the lowest code.
  - err_status sets every flagged bit.
  - err_sel is the lowest set psel index.
- Back-to-back transfers are legal only through IDLE: completion, then a new setup in the next cycle.
- Counters saturate at all-ones. wait_max is clamped to CNT_WIDTH.
- clear zeroes xfer_cnt, slverr_cnt, wait_max and err_status. It does not touch the FSM. If an event coincides with clear, the event wins: the counter reads 1, or the status bit reads set.

## Timing
- Reset values: FSM=IDLE; every output 0. Reset mid-transfer abandons the transfer silently, with no error and no count.
- Error latency: err_valid, err_code and err_sel register one cycle after the offending edge. err_valid is high for exactly one cycle per offending sample.
- Statistics update one cycle after the completing edge.
- Timeout: the error fires on the TIMEOUT-th consecutive pready=0 access sample.
- A completion with pready=1 on the same sample as a control change reports error 5 and is not counted.

## Structure
- Package apb_chk_pkg: state enum (IDLE, ACCESS, ABANDON), err_code enum (values 0–7), and the helper function sel_width(NUM_SEL).
- Sub-module apb_sel_decode: combinational; maps psel to {any, multi, lowest index}. This is the only sub-module.

## Test plan
- Write to slave 2 with 0 wait states, then read with 3 wait states and pslverr=1 → xfer_cnt=2, slverr_cnt=1, wait_max=3, no err_valid.
- psel=4'b0110 in setup → err_valid one cycle later, err_code=1, err_sel=1, err_status=7'b0000001.
- With TIMEOUT=16, pready held low → err_code=6 after the 16th wait sample. FSM stays in ABANDON until psel=0. The next legal transfer gives xfer_cnt=1.
- paddr changed from 0x100 to 0x104 during the wait state of a write → err_code=5, transfer not counted.
- Read setup with pstrb=4'hF and penable=1 in the same cycle → err_code=3, err_status bits 2 and 6 set.
- clear asserted on the same edge as a completion, with xfer_cnt=5 → xfer_cnt=1. Reset asserted mid-access → all outputs 0, no error pulse.
